// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS subset: opcodes, functs, ALU ops.
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGT   = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Link register written by jal
  localparam logic [4:0] RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU; also supplies the equality and signed-greater flags used by branches.
module mips_alu
  import mips_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  input  alu_op_t     alu_op,
  output logic [31:0] result,
  output logic        zero,
  output logic        signed_gt
);

  // Operation select; every path assigns result so no latch can form
  always_comb begin
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_LUI: result = {b[15:0], 16'd0};
      default: result = a + b;
    endcase
  end

  assign zero      = (result == 32'd0);
  assign signed_gt = ($signed(a) > $signed(b));

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-subset core: one instruction commits per rising edge, no delay slots.
module mips_cpu
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int DMEM_WORDS = 256
) (
  input logic                      clk,
  input logic                      rst,
  input logic [32*IMEM_WORDS-1:0]  instruction_stream
);

  localparam int PC_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [PC_W-1:0] pc;
  logic [31:0]     regs [32];
  logic [31:0]     dmem [DMEM_WORDS];

  // Fetch and field split
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  assign instr  = instruction_stream[{pc, 5'd0} +: 32];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];

  logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
  assign rs_val   = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'd0, imm};

  // Control signals
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_result;
  logic        alu_zero, alu_gt;
  logic        reg_we, mem_we, is_load, is_link;
  logic [4:0]  wr_idx;

  mips_alu u_alu (
    .a         (rs_val),
    .b         (alu_b),
    .shamt     (shamt),
    .alu_op    (alu_op),
    .result    (alu_result),
    .zero      (alu_zero),
    .signed_gt (alu_gt)
  );

  // Control decode: ALU operation, operand select and write enables
  always_comb begin
    // NOTE: every output gets a default up front so no path through the case infers a latch.
    alu_op  = ALU_ADD;
    alu_b   = rt_val;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    is_load = 1'b0;
    is_link = 1'b0;
    wr_idx  = rd;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:          alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          default:         reg_we = 1'b0;  // jr and unknown functs write nothing
        endcase
      end
      OP_ADDI: begin alu_b = imm_sext; wr_idx = rt; reg_we = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; alu_b = imm_sext; wr_idx = rt; reg_we = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zext; wr_idx = rt; reg_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zext; wr_idx = rt; reg_we = 1'b1; end
      OP_LUI:  begin alu_op = ALU_LUI; alu_b = imm_zext; wr_idx = rt; reg_we = 1'b1; end
      OP_LW:   begin alu_b = imm_sext; wr_idx = rt; reg_we = 1'b1; is_load = 1'b1; end
      OP_SW:   begin alu_b = imm_sext; mem_we = 1'b1; end
      OP_BEQ, OP_BNE, OP_BGT: alu_op = ALU_SUB;
      OP_JAL:  begin wr_idx = RA; reg_we = 1'b1; is_link = 1'b1; end
      default: ;
    endcase
  end

  // Writeback data and next-PC selection from the ALU flags
  logic [PC_W-1:0] pc_plus1, next_pc;
  logic [31:0]     wr_data;
  logic [DA_W-1:0] daddr;

  assign pc_plus1 = pc + PC_W'(1);
  assign daddr    = alu_result[DA_W-1:0];

  always_comb begin
    next_pc = pc_plus1;
    if (is_link)      wr_data = 32'(pc_plus1);
    else if (is_load) wr_data = dmem[daddr];
    else              wr_data = alu_result;
    case (opcode)
      OP_RTYPE: if (funct == FN_JR) next_pc = rs_val[PC_W-1:0];
      OP_BEQ:   if (alu_zero)       next_pc = pc + imm[PC_W-1:0];
      OP_BNE:   if (!alu_zero)      next_pc = pc + imm[PC_W-1:0];
      OP_BGT:   if (alu_gt)         next_pc = pc + imm[PC_W-1:0];
      OP_J, OP_JAL:                 next_pc = instr[PC_W-1:0];
      default: ;
    endcase
  end

  // Architectural state commit; reset wins over any instruction that cycle
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (rst) begin
      pc <= '0;
      // NOTE: register file and data memory are cleared on reset, which forces flop storage rather than RAM macros.
      for (int i = 0; i < 32; i++)         regs[i] <= '0;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
    end else begin
      pc <= next_pc;
      if (reg_we && wr_idx != 5'd0) regs[wr_idx] <= wr_data;
      if (mem_we) dmem[daddr] <= rt_val;
    end
  end

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed program checks plus random programs against an instruction-level model.
module tb_mips_cpu;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [32767:0] prog = '0;

  mips_cpu dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_stream (prog)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] imem   [1024];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  int          m_pc;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd, int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int target);
    return {6'(op), 26'(target)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'd0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) prog[32*i +: 32] = imem[i];
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++)  m_regs[i] = 32'd0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 32'd0;
  endtask

  // Executes one instruction on the model using the ISA rules directly
  task automatic model_step();
    logic [31:0] w, a, b, res, simm, zimm;
    logic [5:0]  op, fn;
    logic [4:0]  sh;
    int          rs, rt, rd, npc, wr;
    w    = imem[m_pc];
    op   = w[31:26];
    fn   = w[5:0];
    sh   = w[10:6];
    rs   = int'(w[25:21]);
    rt   = int'(w[20:16]);
    rd   = int'(w[15:11]);
    a    = m_regs[rs];
    b    = m_regs[rt];
    simm = {{16{w[15]}}, w[15:0]};
    zimm = {16'd0, w[15:0]};
    npc  = (m_pc + 1) % 1024;
    wr   = -1;
    res  = 32'd0;
    case (op)
      6'h00: case (fn)
        6'h20, 6'h21: begin wr = rd; res = a + b; end
        6'h22: begin wr = rd; res = a - b; end
        6'h24: begin wr = rd; res = a & b; end
        6'h25: begin wr = rd; res = a | b; end
        6'h26: begin wr = rd; res = a ^ b; end
        6'h27: begin wr = rd; res = ~(a | b); end
        6'h2A: begin wr = rd; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        6'h00: begin wr = rd; res = b << sh; end
        6'h02: begin wr = rd; res = b >> sh; end
        6'h08: npc = int'(a % 1024);
        default: ;
      endcase
      6'h08: begin wr = rt; res = a + simm; end
      6'h0A: begin wr = rt; res = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = rt; res = a & zimm; end
      6'h0D: begin wr = rt; res = a | zimm; end
      6'h0F: begin wr = rt; res = {w[15:0], 16'd0}; end
      6'h23: begin wr = rt; res = m_dmem[int'((a + simm) % 256)]; end
      6'h2B: m_dmem[int'((a + simm) % 256)] = b;
      6'h04: if (a == b) npc = (m_pc + int'($signed(simm))) & 1023;
      6'h05: if (a != b) npc = (m_pc + int'($signed(simm))) & 1023;
      6'h06: if ($signed(a) > $signed(b)) npc = (m_pc + int'($signed(simm))) & 1023;
      6'h02: npc = int'(w[25:0]) % 1024;
      6'h03: begin wr = 31; res = 32'((m_pc + 1) % 1024); npc = int'(w[25:0]) % 1024; end
      default: ;
    endcase
    if (wr > 0) m_regs[wr] = res;
    m_pc = npc;
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s pc", tag), 32'(dut.pc), 32'(m_pc));
    for (int r = 0; r < 32; r++)
      check($sformatf("%s r%0d", tag, r), dut.regs[r], m_regs[r]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  task automatic step(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_step();
      compare_all(tag);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [11];
    int         k, rs, rt, rd;
    fns = '{6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h3F};
    k  = int'($urandom_range(0, 13));
    rs = int'($urandom_range(0, 7));
    rt = int'($urandom_range(0, 7));
    rd = int'($urandom_range(0, 7));
    case (k)
      0, 1, 2: return enc_r(int'(fns[$urandom_range(0, 10)]), rs, rt, rd, int'($urandom_range(0, 31)));
      3:  return enc_i(6'h08, rs, rt, int'($urandom_range(0, 65535)));
      4:  return enc_i(6'h0A, rs, rt, int'($urandom_range(0, 65535)));
      5:  return enc_i(6'h0C, rs, rt, int'($urandom_range(0, 65535)));
      6:  return enc_i(6'h0D, rs, rt, int'($urandom_range(0, 65535)));
      7:  return enc_i(6'h0F, rs, rt, int'($urandom_range(0, 65535)));
      8:  return enc_i(6'h23, rs, rt, int'($urandom_range(0, 65535)));
      9:  return enc_i(6'h2B, rs, rt, int'($urandom_range(0, 65535)));
      10: return enc_i(int'($urandom_range(4, 6)), rs, rt, int'($urandom_range(0, 8)) - 4);
      11: return enc_j(int'($urandom_range(2, 3)), int'($urandom_range(0, 63)));
      12: return enc_i(6'h3E, rs, rt, int'($urandom_range(0, 65535)));
      default: return enc_i(6'h08, 0, rt, int'($urandom_range(0, 65535)));
    endcase
  endfunction

  // Directed program used for branch/jump checks; variant 1 flips beq and makes $3 negative
  task automatic build_branch_prog(input bit variant);
    clear_imem();
    imem[0]  = enc_i(6'h08, 0, 1, 5);
    imem[1]  = enc_i(6'h08, 0, 2, 2);
    imem[2]  = enc_i(6'h08, 0, 3, variant ? -1 : 7);
    imem[3]  = enc_i(6'h04, 1, variant ? 2 : 1, 2);
    imem[4]  = enc_i(6'h08, 0, 4, 15);
    imem[5]  = enc_i(6'h08, 0, 4, 10);
    imem[6]  = enc_i(6'h05, 1, 2, 2);
    imem[7]  = enc_i(6'h08, 0, 5, 99);
    imem[8]  = enc_i(6'h08, 0, 5, 2);
    imem[9]  = enc_i(6'h06, 3, 1, 2);
    imem[10] = enc_i(6'h08, 0, 6, 99);
    imem[11] = enc_i(6'h08, 0, 6, 3);
    imem[12] = enc_j(6'h02, 13);
    imem[13] = enc_i(6'h08, 0, 7, 13);
    imem[14] = enc_j(6'h03, 15);
    imem[15] = enc_i(6'h08, 0, 8, 15);
    imem[16] = enc_r(6'h08, 31, 0, 0, 0);
    load_prog();
  endtask

  initial begin
    // Reset, straight-line addi, taken branches and jumps
    build_branch_prog(1'b0);
    do_reset();
    check("reset pc", 32'(dut.pc), 32'd0);
    step(3, "load");
    check("r1 load", dut.regs[1], 32'd5);
    check("r2 load", dut.regs[2], 32'd2);
    check("r3 load", dut.regs[3], 32'd7);
    check("pc after 3", 32'(dut.pc), 32'd3);
    step(1, "beq");
    check("beq taken pc", 32'(dut.pc), 32'd5);
    step(1, "w5");
    check("r4 beq", dut.regs[4], 32'd10);
    step(1, "bne");
    check("bne taken pc", 32'(dut.pc), 32'd8);
    step(2, "bgt");
    check("r5 bne", dut.regs[5], 32'd2);
    check("bgt taken pc", 32'(dut.pc), 32'd11);
    step(1, "w11");
    check("r6 bgt", dut.regs[6], 32'd3);
    step(1, "j");
    check("j pc", 32'(dut.pc), 32'd13);
    step(2, "jal");
    check("r7 j", dut.regs[7], 32'd13);
    check("jal pc", 32'(dut.pc), 32'd15);
    check("r31 jal", dut.regs[31], 32'd15);
    step(2, "jr");
    check("r8", dut.regs[8], 32'd15);
    check("jr pc", 32'(dut.pc), 32'd15);
    for (int k = 0; k < 4; k++) begin
      step(1, "loop");
      check("loop pc", 32'(dut.pc), (k % 2 == 0) ? 32'd16 : 32'd15);
    end

    // Not-taken branch variant
    build_branch_prog(1'b1);
    do_reset();
    step(3, "v1 load");
    check("r3 neg", dut.regs[3], 32'hFFFF_FFFF);
    step(1, "v1 beq");
    check("beq not taken pc", 32'(dut.pc), 32'd4);
    step(1, "v1 w4");
    check("r4 fall", dut.regs[4], 32'd15);
    step(1, "v1 w5");
    check("r4 over", dut.regs[4], 32'd10);
    step(3, "v1 bgt");
    check("bgt not taken pc", 32'(dut.pc), 32'd10);
    step(1, "v1 w10");
    check("r6 fall", dut.regs[6], 32'd99);
    step(1, "v1 w11");
    check("r6 over", dut.regs[6], 32'd3);

    // $0, overflow wrap, lui/ori, memory, pc wrap, mid-run reset
    clear_imem();
    imem[0]    = enc_i(6'h08, 0, 0, 9);
    imem[1]    = enc_i(6'h0F, 0, 11, 16'h7FFF);
    imem[2]    = enc_i(6'h0D, 11, 11, 16'hFFFF);
    imem[3]    = enc_i(6'h08, 11, 12, 1);
    imem[4]    = enc_i(6'h0F, 0, 9, 16'hABCD);
    imem[5]    = enc_i(6'h0D, 9, 9, 16'h1234);
    imem[6]    = enc_i(6'h2B, 0, 9, 4);
    imem[7]    = enc_i(6'h23, 0, 10, 4);
    imem[8]    = enc_j(6'h02, 1023);
    imem[1023] = enc_i(6'h08, 0, 14, 77);
    load_prog();
    do_reset();
    step(1, "r0");
    check("r0 stays 0", dut.regs[0], 32'd0);
    step(2, "max");
    check("r11 max", dut.regs[11], 32'h7FFF_FFFF);
    step(1, "ovf");
    check("r12 wrap", dut.regs[12], 32'h8000_0000);
    step(2, "lui");
    check("r9 lui ori", dut.regs[9], 32'hABCD_1234);
    step(1, "sw");
    check("dmem4", dut.dmem[4], 32'hABCD_1234);
    step(1, "lw");
    check("r10 lw", dut.regs[10], 32'hABCD_1234);
    step(1, "j1023");
    check("pc 1023", 32'(dut.pc), 32'd1023);
    step(1, "wrap");
    check("pc wrap", 32'(dut.pc), 32'd0);
    check("r14", dut.regs[14], 32'd77);
    step(3, "rerun");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid rst pc", 32'(dut.pc), 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("mid rst r%0d", r), dut.regs[r], 32'd0);
    check("mid rst dmem4", dut.dmem[4], 32'd0);
    rst = 1'b0;
    model_reset();

    // Random programs in lockstep with the model
    for (int round = 0; round < 4; round++) begin
      clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = rand_instr();
      load_prog();
      do_reset();
      step(150, $sformatf("rand%0d", round));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
